// File: rtl/unpack_blk_stream_core.sv
// Serialises one packed block of WORDS words onto an AXI4-Stream master, word 0 first,
// and exports stall/idle flags for the downstream deadlock monitor.
module unpack_blk_stream_core #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [DATA_W*WORDS-1:0]   blk_tdata,
  input  logic                      blk_tvalid,
  output logic                      blk_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [1:0]                axis_block_sigs,
  output logic                      inst_idle,
  output logic [CNT_W-1:0]          blk_count
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          idx_nxt_s;
  logic [DATA_W*WORDS-1:0]   block_r;
  logic [CNT_W-1:0]          count_r;
  logic                      beat_s;
  logic                      last_beat_s;
  logic                      load_s;
  logic [DATA_W-1:0]         words_s [WORDS];

  // Word view of the registered block so the output mux is a plain array index.
  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign words_s[k] = block_r[k*DATA_W +: DATA_W];
  end

  // Handshake decode; the last beat is the only path from m_axis_tready to blk_tready.
  always_comb begin
    beat_s      = (state_r == SEND) && m_axis_tready;
    last_beat_s = beat_s && (idx_r == LAST_IDX);
    blk_tready  = (state_r == IDLE) || last_beat_s;
    load_s      = blk_tvalid && blk_tready;
  end

  // Next-state and word index; a new block on the last beat keeps SEND with no bubble.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_nxt_s = SEND;
          idx_nxt_s   = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (last_beat_s) begin
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = blk_tvalid ? SEND : IDLE;
        end else if (beat_s) begin
          idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, index, block capture and completed-block counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      block_r <= {(DATA_W*WORDS){1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (load_s) begin
        block_r <= blk_tdata;
      end
      if (last_beat_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  // Stream outputs come straight from registers, so they hold while tready is low.
  always_comb begin
    m_axis_tvalid   = (state_r == SEND);
    m_axis_tdata    = words_s[idx_r];
    m_axis_tlast    = (state_r == SEND) && (idx_r == LAST_IDX);
    inst_idle       = (state_r == IDLE);
    blk_count       = count_r;
    axis_block_sigs = {blk_tvalid && !blk_tready, m_axis_tvalid && !m_axis_tready};
  end

endmodule

// File: tb/tb_unpack_blk_stream_core.sv
// Directed bench: WORDS=4 instance for the main paths, WORDS=1/CNT_W=2 instance for
// single-word blocks and counter wrap.
module tb_unpack_blk_stream_core;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic [127:0]  blk_tdata;
  logic          blk_tvalid;
  logic          blk_tready;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [1:0]    axis_block_sigs;
  logic          inst_idle;
  logic [15:0]   blk_count;

  logic [31:0]   b1_tdata;
  logic          b1_tvalid;
  logic          b1_tready;
  logic [31:0]   s1_tdata;
  logic          s1_tvalid;
  logic          s1_tready;
  logic          s1_tlast;
  logic [1:0]    s1_block_sigs;
  logic          s1_idle;
  logic [1:0]    s1_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  unpack_blk_stream_core #(.DATA_W(32), .WORDS(4), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .blk_tdata(blk_tdata), .blk_tvalid(blk_tvalid), .blk_tready(blk_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .axis_block_sigs(axis_block_sigs), .inst_idle(inst_idle), .blk_count(blk_count)
  );

  unpack_blk_stream_core #(.DATA_W(32), .WORDS(1), .CNT_W(2)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .blk_tdata(b1_tdata), .blk_tvalid(b1_tvalid), .blk_tready(b1_tready),
    .m_axis_tdata(s1_tdata), .m_axis_tvalid(s1_tvalid),
    .m_axis_tready(s1_tready), .m_axis_tlast(s1_tlast),
    .axis_block_sigs(s1_block_sigs), .inst_idle(s1_idle), .blk_count(s1_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed at posedge+1, outputs checked at posedge+2.
  task automatic edge1();
    @(posedge ap_clk);
    #1;
  endtask

  logic [0:0]  bp_rdy [12];
  logic [31:0] bp_dat [12];
  logic [1:0]  bp_sig [12];

  initial begin
    ap_rst_n      = 1'b0;
    blk_tdata     = 128'h0;
    blk_tvalid    = 1'b0;
    m_axis_tready = 1'b1;
    b1_tdata      = 32'h0;
    b1_tvalid     = 1'b0;
    s1_tready     = 1'b1;
    #12;
    chk("rst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    chk("rst_tlast", {63'h0, m_axis_tlast}, 64'h0);
    chk("rst_tdata", {32'h0, m_axis_tdata}, 64'h0);
    chk("rst_idle", {63'h0, inst_idle}, 64'h1);
    chk("rst_count", {48'h0, blk_count}, 64'h0);
    chk("rst_tready", {63'h0, blk_tready}, 64'h1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single block, words 1..4.
    edge1();
    blk_tdata  = 128'h00000004_00000003_00000002_00000001;
    blk_tvalid = 1'b1;
    #1;
    chk("single_hs_ready", {63'h0, blk_tready}, 64'h1);
    edge1();
    blk_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("single_tvalid", {63'h0, m_axis_tvalid}, 64'h1);
      chk("single_tdata", {32'h0, m_axis_tdata}, 64'(k + 1));
      chk("single_tlast", {63'h0, m_axis_tlast}, (k == 3) ? 64'h1 : 64'h0);
      edge1();
    end
    #1;
    chk("single_done_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    chk("single_done_idle", {63'h0, inst_idle}, 64'h1);
    chk("single_done_count", {48'h0, blk_count}, 64'h1);

    // Back-to-back blocks A=1..4, B=5..8 with no gap.
    blk_tdata  = 128'h00000004_00000003_00000002_00000001;
    blk_tvalid = 1'b1;
    edge1();
    blk_tdata = 128'h00000008_00000007_00000006_00000005;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("b2b_tvalid", {63'h0, m_axis_tvalid}, 64'h1);
      chk("b2b_tdata", {32'h0, m_axis_tdata}, 64'(k + 1));
      chk("b2b_tlast", {63'h0, m_axis_tlast}, (k == 3 || k == 7) ? 64'h1 : 64'h0);
      chk("b2b_blk_tready", {63'h0, blk_tready}, (k == 3 || k == 7) ? 64'h1 : 64'h0);
      edge1();
      if (k == 3) blk_tvalid = 1'b0;
    end
    #1;
    chk("b2b_idle", {63'h0, inst_idle}, 64'h1);
    chk("b2b_count", {48'h0, blk_count}, 64'h3);

    // Backpressure on cycles 2-5 of block C with block D waiting.
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bp_dat = '{32'h11, 32'h12, 32'h12, 32'h12, 32'h12, 32'h12, 32'h13, 32'h14,
               32'h21, 32'h22, 32'h23, 32'h24};
    bp_sig = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00,
               2'b00, 2'b00, 2'b00, 2'b00};
    blk_tdata  = 128'h00000014_00000013_00000012_00000011;
    blk_tvalid = 1'b1;
    edge1();
    blk_tdata = 128'h00000024_00000023_00000022_00000021;
    for (int c = 0; c < 12; c++) begin
      m_axis_tready = bp_rdy[c];
      #1;
      chk("bp_tvalid", {63'h0, m_axis_tvalid}, 64'h1);
      chk("bp_tdata", {32'h0, m_axis_tdata}, {32'h0, bp_dat[c]});
      chk("bp_tlast", {63'h0, m_axis_tlast}, (c == 7 || c == 11) ? 64'h1 : 64'h0);
      chk("bp_block_sigs", {62'h0, axis_block_sigs}, {62'h0, bp_sig[c]});
      edge1();
      if (c == 7) blk_tvalid = 1'b0;
    end
    m_axis_tready = 1'b1;
    #1;
    chk("bp_idle", {63'h0, inst_idle}, 64'h1);
    chk("bp_count", {48'h0, blk_count}, 64'h5);

    // Asynchronous reset after word 2 of block E.
    blk_tdata  = 128'h00000034_00000033_00000032_00000031;
    blk_tvalid = 1'b1;
    edge1();
    blk_tvalid = 1'b0;
    edge1();
    edge1();
    #1;
    chk("arst_pre_tdata", {32'h0, m_axis_tdata}, 64'h33);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    chk("arst_idle", {63'h0, inst_idle}, 64'h1);
    chk("arst_count", {48'h0, blk_count}, 64'h0);
    chk("arst_tdata", {32'h0, m_axis_tdata}, 64'h0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    edge1();
    chk("arst_post_idle", {63'h0, inst_idle}, 64'h1);
    blk_tdata  = 128'h00000044_00000043_00000042_00000041;
    blk_tvalid = 1'b1;
    edge1();
    blk_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arst_next_tdata", {32'h0, m_axis_tdata}, 64'(32'h41 + k));
      chk("arst_next_tlast", {63'h0, m_axis_tlast}, (k == 3) ? 64'h1 : 64'h0);
      edge1();
    end
    #1;
    chk("arst_next_count", {48'h0, blk_count}, 64'h1);

    // WORDS=1, CNT_W=2: five back-to-back single-word blocks, counter 0,1,2,3,0 then 1.
    b1_tdata  = 32'hA1;
    b1_tvalid = 1'b1;
    edge1();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) b1_tdata = 32'hA2 + i;
      else b1_tvalid = 1'b0;
      #1;
      chk("w1_tvalid", {63'h0, s1_tvalid}, 64'h1);
      chk("w1_tdata", {32'h0, s1_tdata}, 64'(32'hA1 + i));
      chk("w1_tlast", {63'h0, s1_tlast}, 64'h1);
      chk("w1_blk_tready", {63'h0, b1_tready}, 64'h1);
      chk("w1_count", {62'h0, s1_count}, 64'(i % 4));
      edge1();
    end
    #1;
    chk("w1_final_tvalid", {63'h0, s1_tvalid}, 64'h0);
    chk("w1_final_count", {62'h0, s1_count}, 64'h1);
    chk("w1_final_idle", {63'h0, s1_idle}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
